eq_bist_driver: RTL

//  Hardware stimulus/response engine for the WIDTH-bit equality comparator (eq2 family).

---
 rtl/eq_bist_pkg.sv | 17 +
 rtl/eq_vec_sweep.sv | 44 ++++
 rtl/eq_bist_driver.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/eq_bist_pkg.sv
// Shared types and helpers for the equality-comparator BIST engine.
//   eq_bist_state_t : sweep controller state encoding
//   n_vectors()     : number of (a,b) operand pairs for a given operand width
package eq_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } eq_bist_state_t;

  function automatic int unsigned n_vectors(input int unsigned width);
    return 32'(1) << (2 * width);
  endfunction

endpackage

// File: rtl/eq_vec_sweep.sv
// Operand-pair index counter for the equality BIST sweep.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   clr_i      : force index to 0 (wins over inc_i)
//   inc_i      : advance index; saturates at the last vector, never wraps
//   idx_o      : current index, {a, b} concatenated
//   last_o     : index is at its final value
module eq_vec_sweep #(
  parameter int unsigned WIDTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr_i,
  input  logic               inc_i,
  output logic [2*WIDTH-1:0] idx_o,
  output logic               last_o
);

  localparam int unsigned IDX_W = 2 * WIDTH;

  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;

  // Next index: clear has priority, increment holds at the final vector.
  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (inc_i && !last_o) begin
      idx_d = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx_o  = idx_q;
  assign last_o = (idx_q == {IDX_W{1'b1}});

endmodule

// File: rtl/eq_bist_driver.sv
// Stimulus/response engine for a WIDTH-bit equality comparator. Sweeps every
// (a,b) pair, holds each for SETTLE_CYC cycles, then samples dut_aeqb once and
// checks it against a == b.
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   start           : one-cycle request, honoured only in IDLE or DONE
//   dut_aeqb        : comparator equality output under test
//   a_out, b_out    : registered operands to the comparator
//   busy            : sweep in progress
//   done            : sweep finished, held until start or reset
//   pass            : done with zero mismatches (combinational)
//   err_cnt         : mismatching vector count, wide enough to never overflow
//   fail_valid      : first_fail_a/b hold a captured pair
//   first_fail_a/b  : operands of the first mismatching vector
module eq_bist_driver
  import eq_bist_pkg::*;
#(
  parameter int unsigned WIDTH      = 2,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               dut_aeqb,
  output logic [WIDTH-1:0]   a_out,
  output logic [WIDTH-1:0]   b_out,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_cnt,
  output logic               fail_valid,
  output logic [WIDTH-1:0]   first_fail_a,
  output logic [WIDTH-1:0]   first_fail_b
);

  localparam int unsigned IDX_W = 2 * WIDTH;
  localparam int unsigned ERR_W = 2 * WIDTH + 1;
  localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  eq_bist_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             fv_q, fv_d;
  logic [WIDTH-1:0] ffa_q, ffa_d;
  logic [WIDTH-1:0] ffb_q, ffb_d;

  logic             sweep_clr;
  logic             sweep_inc;
  logic [IDX_W-1:0] sweep_idx;
  logic             sweep_last;
  logic             expected_c;

  eq_vec_sweep #(
    .WIDTH (WIDTH)
  ) u_sweep (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (sweep_clr),
    .inc_i  (sweep_inc),
    .idx_o  (sweep_idx),
    .last_o (sweep_last)
  );

  // The operands are the index halves, so they are registered by construction.
  assign a_out      = sweep_idx[IDX_W-1:WIDTH];
  assign b_out      = sweep_idx[WIDTH-1:0];
  assign expected_c = (a_out == b_out);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and result-register logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    fv_d      = fv_q;
    ffa_d     = ffa_q;
    ffb_d     = ffb_q;
    sweep_clr = 1'b0;
    sweep_inc = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sweep_clr = 1'b1;
          cnt_d     = '0;
          err_d     = '0;
          fv_d      = 1'b0;
          ffa_d     = '0;
          ffb_d     = '0;
          done_d    = 1'b0;
          busy_d    = 1'b1;
          state_d   = SETTLE;
        end
      end

      SETTLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
          state_d = CHECK;
        end
      end

      CHECK: begin
        // dut_aeqb is looked at only here; settle-window glitches never count.
        if (dut_aeqb != expected_c) begin
          err_d = err_q + ERR_W'(1);
          if (!fv_q) begin
            fv_d  = 1'b1;
            ffa_d = a_out;
            ffb_d = b_out;
          end
        end
        if (sweep_last) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end else begin
          sweep_inc = 1'b1;
          cnt_d     = '0;
          state_d   = SETTLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath/result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= '0;
      fv_q   <= 1'b0;
      ffa_q  <= '0;
      ffb_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q  <= err_d;
      fv_q   <= fv_d;
      ffa_q  <= ffa_d;
      ffb_q  <= ffb_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = done_q && (err_q == '0);
  assign err_cnt      = err_q;
  assign fail_valid   = fv_q;
  assign first_fail_a = ffa_q;
  assign first_fail_b = ffb_q;

endmodule
